channel_rr_arbiter: RTL and testbench
=====================================

# channel_rr_arbiter

Round-robin readout arbiter placed directly upstream of `one_hot_select` in the TDC channel-merge path. Watches the per-channel "not empty" flags of DATA_DEPTH show-ahead channel FIFOs, issues a one-hot grant, and pops the granted FIFO. Registers the selected word, with its channel number, into a single output stage with a valid/ready handshake. Guarantees fair service: no channel waits more than DATA_DEPTH-1 grants while it holds data.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one channel word.
- `DATA_DEPTH`, 8: number of channels (≥2).
- `CHNL_W`, derived as clog2(DATA_DEPTH): width of the channel-id field. Not user-overridden.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  arbitration enable; low blocks new grants.
- `ch_valid`  in  DATA_DEPTH  per-channel FIFO non-empty.
- `ch_data`  in  DATA_WIDTH*DATA_DEPTH  show-ahead FIFO heads; channel i at bits [(i+1)*W-1 : i*W].
- `ch_read`  out  DATA_DEPTH  one-hot pop strobe, at most one bit high per cycle.
- `grant`  out  DATA_DEPTH  one-hot grant, equal to `ch_read`; drives `one_hot_select`.
- `out_data`  out  DATA_WIDTH  registered selected word.
- `out_chnl`  out  CHNL_W  channel index of `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts the word when high with `out_valid`.
- `word_cnt`  out  16  total words transferred (out_valid & out_ready), wraps at 65535→0.

## Operation
- FSM, two states:
  - IDLE: `enable` low. No grants are issued. A held output word still drains.
  - RUN: `enable` high.
  - Transition on `enable` level, registered. IDLE→RUN takes effect the cycle after `enable` rises.
- `load = ~out_valid | out_ready`. In RUN with `load` and `|ch_valid`, grant exactly one channel.
- Round-robin pointer `last` (CHNL_W bits):
  - Search order is last+1, last+2, …, wrapping modulo DATA_DEPTH. The first asserted `ch_valid` wins.
  - On every grant, `last` ← granted index.
  - After DATA_DEPTH-1, `last` wraps to 0.
- On grant:
  - `ch_read`/`grant` go high for that channel, combinationally, in the same cycle.
  - Next edge: `out_data` ← that channel's `ch_data`, `out_chnl` ← index, `out_valid` ← 1.
- `out_valid & out_ready` without a new grant: `out_valid` ← 0 next edge.
- Stall (`out_valid & ~out_ready`):
  - `out_data`/`out_chnl` remain stable.
  - No `ch_read`.
  - `last` does not change.
- Disable mid-stream: a word already registered stays valid until accepted. No further grants.
- `word_cnt` increments on each accepted transfer, independent of FSM state.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_chnl`=0, `word_cnt`=0.
  - `ch_read`=`grant`=0.
  - State=IDLE.
  - `last`=DATA_DEPTH-1, so channel 0 is granted first.
- Latency: pop cycle N → `out_valid` at N+1.
- Throughput: one word per cycle while `out_ready` is held high and any channel has data. A single requester can be granted every cycle.
- Combinational path exists from `out_ready` and `ch_valid` to `ch_read`. Downstream must drive `out_ready` from a register.
- Reset asserted mid-transfer: all state clears immediately. Any pop issued in the reset cycle is void, and FIFOs are reset together.

## Structure
- Shared project include holds the `clog2` function and the FSM state localparams (ST_IDLE=1'b0, ST_RUN=1'b1).
- Natural sub-module: `one_hot_select` (DATA_WIDTH, DATA_DEPTH) instantiated with `grant` and `ch_data` to form the word loaded into `out_data`.
- The round-robin priority search is a generate loop over a doubled request vector rotated by `last`. No separate module.

## Test plan
- Reset, `enable`=1, `ch_valid`=8'h01, `ch_data[31:0]`=32'hA5A5_0001, `out_ready`=1 → `ch_read`=8'h01 one cycle; next cycle `out_data`=32'hA5A5_0001, `out_chnl`=0, `out_valid`=1.
- `ch_valid`=8'hFF held, `out_ready`=1 → grant order ch0,1,…,7,0 on consecutive cycles; `word_cnt` reaches 9 after 9 transfers.
- `ch_valid`=8'h81, `last`=7 → ch0 granted, then ch7, then ch0 (wrap-around fairness).
- `out_ready`=0 for 5 cycles with `out_valid`=1 → `out_data`/`out_chnl` stable, `ch_read`=0, `last` unchanged; `out_ready`=1 → transfer accepted and next grant issued the same cycle.
- `enable` dropped while a word is held and `ch_valid`=8'h0F → held word accepted, then no `ch_read` until `enable` rises again; resume grants from `last`+1.
- `rst_n` pulsed low mid-stream → all outputs at reset values asynchronously; first grant after release is the lowest-index valid channel.

Source files
------------

// File: rtl/channel_rr_arbiter_pkg.sv
// Shared types, constants and helpers for the TDC channel-merge round-robin arbiter.
package channel_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 16;

  // Ceiling log2 usable in constant expressions; callers guarantee v >= 2.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/channel_rr_arbiter_if.sv
// Channel-FIFO side and output-stage side of the arbiter, bundled as one bus.
interface channel_rr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 8
);
  import channel_rr_arbiter_pkg::*;

  localparam int unsigned CHNL_W = clog2(DATA_DEPTH);

  logic [DATA_DEPTH-1:0]            ch_valid;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] ch_data;
  logic [DATA_DEPTH-1:0]            ch_read;
  logic [DATA_DEPTH-1:0]            grant;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CHNL_W-1:0]                out_chnl;
  logic                             out_valid;
  logic                             out_ready;

  // Environment side: FIFOs plus downstream consumer.
  modport master (
    output ch_valid, ch_data, out_ready,
    input  ch_read, grant, out_data, out_chnl, out_valid
  );

  // Arbiter side.
  modport slave (
    input  ch_valid, ch_data, out_ready,
    output ch_read, grant, out_data, out_chnl, out_valid
  );

endinterface

// File: rtl/channel_rr_arbiter_one_hot_select.sv
// One-hot word selector: ORs together the channel words whose select bit is set.
module channel_rr_arbiter_one_hot_select #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 8
) (
  input  logic [DATA_DEPTH-1:0]            sel_i,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0]            data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(DATA_DEPTH); i++) begin
      data_o = data_o | ({DATA_WIDTH{sel_i[i]}} & data_i[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

endmodule

// File: rtl/channel_rr_arbiter.sv
// Round-robin readout arbiter: pops one show-ahead channel FIFO per cycle into a
// single valid/ready output register tagged with its channel number.
module channel_rr_arbiter
  import channel_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  channel_rr_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]        word_cnt
);

  localparam int unsigned CHNL_W = clog2(DATA_DEPTH);
  localparam int unsigned PTR_W  = CHNL_W + 1;

  state_e                  state_q;
  logic [CHNL_W-1:0]       last_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CHNL_W-1:0]       out_chnl_q;
  logic                    out_valid_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    load_c;
  logic                    do_grant_c;
  logic                    accept_c;
  logic [PTR_W-1:0]        shift_c;
  logic [2*DATA_DEPTH-1:0] req_dbl_c;
  logic [DATA_DEPTH-1:0]   req_rot_c;
  logic [DATA_DEPTH-1:0]   seen_c;
  logic [DATA_DEPTH-1:0]   first_hit_c;
  logic [2*DATA_DEPTH-1:0] gnt_dbl_c;
  logic [DATA_DEPTH-1:0]   gnt_raw_c;
  logic [DATA_DEPTH-1:0]   ch_read_c;
  logic [CHNL_W-1:0]       gnt_idx_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;

  assign load_c     = ~out_valid_q | bus.out_ready;
  assign accept_c   = out_valid_q & bus.out_ready;
  assign do_grant_c = (state_q == ST_RUN) & load_c & (|bus.ch_valid);

  // Rotate the doubled request vector so bit 0 is channel last+1.
  assign shift_c   = PTR_W'(last_q) + PTR_W'(1);
  assign req_dbl_c = {bus.ch_valid, bus.ch_valid};
  assign req_rot_c = DATA_DEPTH'(req_dbl_c >> shift_c);
  assign seen_c[0] = 1'b0;

  for (genvar j = 0; j < int'(DATA_DEPTH); j++) begin : g_pri
    assign first_hit_c[j] = req_rot_c[j] & ~seen_c[j];
    if (j < int'(DATA_DEPTH) - 1) begin : g_chain
      assign seen_c[j+1] = seen_c[j] | req_rot_c[j];
    end
  end

  // Undo the rotation; the upper half carries the wrapped-around positions.
  assign gnt_dbl_c = {{DATA_DEPTH{1'b0}}, first_hit_c} << shift_c;
  assign gnt_raw_c = gnt_dbl_c[DATA_DEPTH-1:0] | gnt_dbl_c[2*DATA_DEPTH-1:DATA_DEPTH];
  assign ch_read_c = do_grant_c ? gnt_raw_c : '0;

  always_comb begin
    gnt_idx_c = '0;
    for (int i = 0; i < int'(DATA_DEPTH); i++) begin
      if (gnt_raw_c[i]) gnt_idx_c = gnt_idx_c | CHNL_W'(i);
    end
  end

  channel_rr_arbiter_one_hot_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_sel (
    .sel_i  (ch_read_c),
    .data_i (bus.ch_data),
    .data_o (sel_data_c)
  );

  // Enable level is sampled into the FSM; the output stage loads on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= CHNL_W'(DATA_DEPTH - 1);
      out_data_q  <= '0;
      out_chnl_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= enable ? ST_RUN : ST_IDLE;
      if (do_grant_c) begin
        last_q      <= gnt_idx_c;
        out_data_q  <= sel_data_c;
        out_chnl_q  <= gnt_idx_c;
        out_valid_q <= 1'b1;
      end else if (accept_c) begin
        out_valid_q <= 1'b0;
      end
      if (accept_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ch_read   = ch_read_c;
  assign bus.grant     = ch_read_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_chnl  = out_chnl_q;
  assign bus.out_valid = out_valid_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_channel_rr_arbiter.sv
// Directed-vector bench for channel_rr_arbiter (8 channels x 32 bits).
module tb_channel_rr_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned N = 8;
  localparam int unsigned NV = 31;

  typedef struct {
    logic        en;
    logic [7:0]  vld;
    logic        rdy;
    logic [7:0]  rd;
    logic        ov;
    logic [2:0]  chnl;
    logic [15:0] cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] word_cnt;

  int n_checks;
  int n_fail;

  vec_t vecs [NV];

  channel_rr_arbiter_if #(.DATA_WIDTH(W), .DATA_DEPTH(N)) bus ();

  channel_rr_arbiter #(.DATA_WIDTH(W), .DATA_DEPTH(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input int unsigned c);
    return 32'hA5A5_0001 + 32'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [7:0] rd, input logic ov,
                             input logic [2:0] chnl, input logic [15:0] cnt);
    chk({tag, ".ch_read"},   32'(bus.ch_read),   32'(rd));
    chk({tag, ".grant"},     32'(bus.grant),     32'(rd));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_chnl"},  32'(bus.out_chnl),  32'(chnl));
    chk({tag, ".word_cnt"},  32'(word_cnt),      32'(cnt));
    if (ov) chk({tag, ".out_data"}, bus.out_data, word_of(int'(chnl)));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // en, ch_valid, out_ready | ch_read, out_valid, out_chnl, word_cnt (sampled before the edge)
    vecs[0]  = '{1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 3'd0, 16'd0};
    vecs[1]  = '{1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 3'd0, 16'd0};
    vecs[2]  = '{1'b1, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd0, 16'd0};
    vecs[3]  = '{1'b1, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd1, 16'd1};
    vecs[4]  = '{1'b1, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd2, 16'd2};
    vecs[5]  = '{1'b1, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd3, 16'd3};
    vecs[6]  = '{1'b1, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd4, 16'd4};
    vecs[7]  = '{1'b1, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd5, 16'd5};
    vecs[8]  = '{1'b1, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd6, 16'd6};
    vecs[9]  = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd7, 16'd7};
    vecs[10] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 3'd0, 16'd8};
    vecs[11] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'd9};
    vecs[12] = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b0, 3'd0, 16'd9};
    vecs[13] = '{1'b1, 8'h81, 1'b1, 8'h01, 1'b1, 3'd7, 16'd9};
    vecs[14] = '{1'b1, 8'h81, 1'b1, 8'h80, 1'b1, 3'd0, 16'd10};
    vecs[15] = '{1'b1, 8'h81, 1'b1, 8'h01, 1'b1, 3'd7, 16'd11};
    vecs[16] = '{1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd0, 16'd12};
    vecs[17] = '{1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd0, 16'd12};
    vecs[18] = '{1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd0, 16'd12};
    vecs[19] = '{1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd0, 16'd12};
    vecs[20] = '{1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd0, 16'd12};
    vecs[21] = '{1'b1, 8'h81, 1'b1, 8'h80, 1'b1, 3'd0, 16'd12};
    vecs[22] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 16'd13};
    vecs[23] = '{1'b0, 8'h0F, 1'b0, 8'h00, 1'b1, 3'd7, 16'd13};
    vecs[24] = '{1'b0, 8'h0F, 1'b0, 8'h00, 1'b1, 3'd7, 16'd13};
    vecs[25] = '{1'b0, 8'h0F, 1'b1, 8'h00, 1'b1, 3'd7, 16'd13};
    vecs[26] = '{1'b0, 8'h0F, 1'b1, 8'h00, 1'b0, 3'd7, 16'd14};
    vecs[27] = '{1'b1, 8'h0F, 1'b1, 8'h00, 1'b0, 3'd7, 16'd14};
    vecs[28] = '{1'b1, 8'h0F, 1'b1, 8'h01, 1'b0, 3'd7, 16'd14};
    vecs[29] = '{1'b1, 8'h0F, 1'b1, 8'h02, 1'b1, 3'd0, 16'd14};
    vecs[30] = '{1'b1, 8'h0F, 1'b1, 8'h04, 1'b1, 3'd1, 16'd15};

    rst_n         = 1'b0;
    enable        = 1'b0;
    bus.ch_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < int'(N); i++) bus.ch_data[i*W +: W] = word_of(i);

    #1;
    chk("reset.ch_read",   32'(bus.ch_read),   32'h0);
    chk("reset.grant",     32'(bus.grant),     32'h0);
    chk("reset.out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset.out_data",  bus.out_data,       32'h0);
    chk("reset.out_chnl",  32'(bus.out_chnl),  32'h0);
    chk("reset.word_cnt",  32'(word_cnt),      32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < int'(NV); v++) begin
      @(negedge clk);
      enable        = vecs[v].en;
      bus.ch_valid  = vecs[v].vld;
      bus.out_ready = vecs[v].rdy;
      #1;
      chk_outputs($sformatf("vec%0d", v), vecs[v].rd, vecs[v].ov, vecs[v].chnl, vecs[v].cnt);
    end

    // Asynchronous reset while a word is held mid-stream.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("arst", 8'h00, 1'b0, 3'd0, 16'd0);
    chk("arst.out_data", bus.out_data, 32'h0);

    // After release: IDLE one cycle, then lowest-index valid channel wins.
    @(negedge clk);
    rst_n         = 1'b1;
    enable        = 1'b1;
    bus.ch_valid  = 8'h0C;
    bus.out_ready = 1'b1;
    #1;
    chk_outputs("post_rst0", 8'h00, 1'b0, 3'd0, 16'd0);
    @(negedge clk);
    #1;
    chk_outputs("post_rst1", 8'h04, 1'b0, 3'd0, 16'd0);

    // A lone requester is granted on consecutive cycles.
    @(negedge clk);
    bus.ch_valid = 8'h04;
    #1;
    chk_outputs("single0", 8'h04, 1'b1, 3'd2, 16'd0);
    @(negedge clk);
    #1;
    chk_outputs("single1", 8'h04, 1'b1, 3'd2, 16'd1);
    @(negedge clk);
    bus.ch_valid = 8'h00;
    #1;
    chk_outputs("single2", 8'h00, 1'b1, 3'd2, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
